// File: rtl/sound_fx.sv
// Turns the ball engine's hit strobes into fixed-length square-wave beeps on one speaker pin.
// Paddle beeps (play_sound2) pre-empt wall/brick beeps; only one beep sounds at a time.
module sound_fx #(
  parameter int unsigned TONE1_DIV  = 28409,
  parameter int unsigned TONE2_DIV  = 14205,
  parameter int unsigned DUR_CYCLES = 2500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       play_sound1,
  input  logic       play_sound2,
  input  logic       mute,
  output logic       speaker,
  output logic [1:0] tone_active
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    TONE1 = 2'b01,
    TONE2 = 2'b10
  } state_t;

  localparam logic [15:0] DIV1_M1 = 16'(TONE1_DIV - 1);
  localparam logic [15:0] DIV2_M1 = 16'(TONE2_DIV - 1);
  localparam logic [23:0] DUR_M1  = 24'(DUR_CYCLES - 1);

  state_t      state_q, state_d;
  logic [23:0] dur_cnt_q, dur_cnt_d;
  logic [15:0] half_cnt_q, half_cnt_d;
  logic        speaker_raw_q, speaker_raw_d;
  logic        s1_q, s1_d;
  logic        s2_q, s2_d;

  logic        start1;
  logic        start2;
  logic [15:0] div_m1;

  // NOTE: every signal driven here gets a default at the top so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    dur_cnt_d     = dur_cnt_q;
    half_cnt_d    = half_cnt_q;
    speaker_raw_d = speaker_raw_q;
    s1_d          = play_sound1;
    s2_d          = play_sound2;

    start1 = play_sound1 & ~s1_q;
    start2 = play_sound2 & ~s2_q;
    div_m1 = (state_q == TONE2) ? DIV2_M1 : DIV1_M1;

    if (start2) begin
      state_d       = TONE2;
      dur_cnt_d     = DUR_M1;
      half_cnt_d    = '0;
      speaker_raw_d = 1'b0;
    end else if (start1 && state_q != TONE2) begin
      state_d       = TONE1;
      dur_cnt_d     = DUR_M1;
      half_cnt_d    = '0;
      speaker_raw_d = 1'b0;
    end else if (state_q == IDLE) begin
      half_cnt_d    = '0;
      speaker_raw_d = 1'b0;
    end else if (dur_cnt_q == '0) begin
      // Last beep cycle: fall silent and leave the tone generator parked at zero.
      state_d       = IDLE;
      half_cnt_d    = '0;
      speaker_raw_d = 1'b0;
    end else begin
      dur_cnt_d = dur_cnt_q - 24'd1;
      if (half_cnt_q == div_m1) begin
        half_cnt_d    = '0;
        speaker_raw_d = ~speaker_raw_q;
      end else begin
        half_cnt_d = half_cnt_q + 16'd1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      dur_cnt_q     <= '0;
      half_cnt_q    <= '0;
      speaker_raw_q <= 1'b0;
      s1_q          <= 1'b0;
      s2_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      dur_cnt_q     <= dur_cnt_d;
      half_cnt_q    <= half_cnt_d;
      speaker_raw_q <= speaker_raw_d;
      s1_q          <= s1_d;
      s2_q          <= s2_d;
    end
  end

  // Mute is the only input allowed to reach the pin combinationally.
  assign speaker = speaker_raw_q & ~mute;

  always_comb begin
    tone_active = 2'b00;
    case (state_q)
      TONE1:   tone_active = 2'b01;
      TONE2:   tone_active = 2'b10;
      default: tone_active = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_sound_fx.sv
// Directed and randomized checks of sound_fx against a beep-age reference model.
// The model tracks which tone is sounding and how many cycles it has been playing.
module tb_sound_fx;

  localparam int T1  = 4;
  localparam int T2  = 2;
  localparam int DUR = 20;

  logic       clk         = 1'b0;
  logic       reset       = 1'b0;
  logic       play_sound1 = 1'b0;
  logic       play_sound2 = 1'b0;
  logic       mute        = 1'b0;
  logic       speaker;
  logic [1:0] tone_active;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: which tone is sounding (0/1/2), cycles since its start, previous strobe samples.
  int   m_tone = 0;
  int   m_age  = 0;
  logic m_p1   = 1'b0;
  logic m_p2   = 1'b0;

  always #5 clk = ~clk;

  sound_fx #(
    .TONE1_DIV (T1),
    .TONE2_DIV (T2),
    .DUR_CYCLES(DUR)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .play_sound1(play_sound1),
    .play_sound2(play_sound2),
    .mute       (mute),
    .speaker    (speaker),
    .tone_active(tone_active)
  );

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic st1, st2;
    if (!reset) begin
      m_tone = 0;
      m_age  = 0;
      m_p1   = 1'b0;
      m_p2   = 1'b0;
    end else begin
      st1  = play_sound1 & ~m_p1;
      st2  = play_sound2 & ~m_p2;
      m_p1 = play_sound1;
      m_p2 = play_sound2;
      if (st2) begin
        m_tone = 2;
        m_age  = 0;
      end else if (st1 && m_tone != 2) begin
        m_tone = 1;
        m_age  = 0;
      end else if (m_tone != 0) begin
        m_age++;
        if (m_age >= DUR) begin
          m_tone = 0;
          m_age  = 0;
        end
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    int         div;
    logic [1:0] exp_tone;
    logic [1:0] exp_spk;
    div      = (m_tone == 2) ? T2 : T1;
    exp_tone = 2'(m_tone);
    exp_spk  = 2'b00;
    if (m_tone != 0 && ((m_age / div) % 2) == 1 && !mute) exp_spk = 2'b01;
    check({tag, "_tone"}, tone_active, exp_tone);
    check({tag, "_spk"}, {1'b0, speaker}, exp_spk);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(tag);
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  initial begin
    #12;
    check("rst_tone", tone_active, 2'b00);
    check("rst_spk", {1'b0, speaker}, 2'b00);
    @(negedge clk);
    reset = 1'b1;
    run("idle", 3);

    // One-cycle wall pulse: 20 cycles of tone 1, toggling every 4.
    play_sound1 = 1'b1;
    step("t1_pulse");
    play_sound1 = 1'b0;
    run("t1_pulse", 29);

    // Paddle strobe held high: exactly one beep.
    play_sound2 = 1'b1;
    run("t2_hold", 50);
    play_sound2 = 1'b0;
    run("t2_hold", 5);

    // Paddle hit pre-empts a running wall beep.
    play_sound1 = 1'b1;
    step("preempt");
    play_sound1 = 1'b0;
    run("preempt", 4);
    play_sound2 = 1'b1;
    step("preempt");
    check("preempt_sw", tone_active, 2'b10);
    play_sound2 = 1'b0;
    run("preempt", 25);

    // Wall hit during a paddle beep is dropped.
    play_sound2 = 1'b1;
    step("ignore");
    play_sound2 = 1'b0;
    run("ignore", 4);
    play_sound1 = 1'b1;
    step("ignore");
    check("ignore_t2", tone_active, 2'b10);
    play_sound1 = 1'b0;
    run("ignore", 25);

    // Simultaneous strobes, then mute in the middle of the beep.
    play_sound1 = 1'b1;
    play_sound2 = 1'b1;
    step("both");
    check("both_t2", tone_active, 2'b10);
    play_sound1 = 1'b0;
    play_sound2 = 1'b0;
    run("both", 5);
    mute = 1'b1;
    run("mute", 6);
    mute = 1'b0;
    run("both", 15);

    // Asynchronous reset in the middle of a beep.
    play_sound1 = 1'b1;
    step("areset");
    play_sound1 = 1'b0;
    run("areset", 6);
    #2;
    reset = 1'b0;
    #1;
    check("areset_tone", tone_active, 2'b00);
    check("areset_spk", {1'b0, speaker}, 2'b00);
    run("in_reset", 2);
    @(negedge clk);
    reset = 1'b1;
    run("after_reset", 25);

    // Strobe held high across reset release triggers exactly once.
    play_sound2 = 1'b1;
    run("held_rst", 3);
    #2;
    reset = 1'b0;
    run("held_rst", 2);
    @(negedge clk);
    reset = 1'b1;
    run("held_rst", 30);
    play_sound2 = 1'b0;
    run("held_rst", 3);

    // Randomized traffic with occasional mute and reset.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 7) == 0) play_sound1 = ~play_sound1;
      if ($urandom_range(0, 11) == 0) play_sound2 = ~play_sound2;
      if ($urandom_range(0, 15) == 0) mute = ~mute;
      reset = ($urandom_range(0, 99) != 0);
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
